// File: rtl/versat_databus_arbiter.sv
// Round-robin databus arbiter: shares one external master port among N_REQ
// Versat IO units. The grant is held for the whole burst and released only
// after the master accepts the last beat. The selected requester's signals
// pass combinationally to the master side, so no data latency is added.
module versat_databus_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           s_valid,
  output logic [N_REQ-1:0]           s_ready,
  input  logic [N_REQ*ADDR_W-1:0]    s_addr,
  input  logic [N_REQ*DATA_W-1:0]    s_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  s_wstrb,
  input  logic [N_REQ*8-1:0]         s_len,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [N_REQ-1:0]           s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic [7:0]                 m_len,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_last,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             own;
  logic             burst_end;

  assign own       = (state_q == ST_OWN);
  assign busy      = own;
  assign s_rdata   = m_rdata;
  assign burst_end = m_valid & m_ready & m_last;

  // Round-robin search: first live request starting just after the last owner.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && s_valid[idx]) begin
        any_req = 1'b1;
        pick    = IDX_W'(idx);
      end
    end
  end

  // Next-state logic: claim in IDLE, release on the accepted last beat.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    if (!own) begin
      if (any_req) begin
        state_d = ST_OWN;
        g_d     = pick;
      end
    end else if (burst_end) begin
      state_d = ST_IDLE;
      ptr_d   = g_q;
    end
  end

  // Arbiter state; ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end

  // Master-side mux from the owner; everything is forced to zero while idle.
  always_comb begin
    int gi;
    gi      = int'(g_q);
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    m_len   = '0;
    if (own) begin
      m_valid = s_valid[gi];
      m_addr  = s_addr[gi*ADDR_W +: ADDR_W];
      m_wdata = s_wdata[gi*DATA_W +: DATA_W];
      m_wstrb = s_wstrb[gi*STRB_W +: STRB_W];
      m_len   = s_len[gi*8 +: 8];
    end
  end

  // Requester-side handshake: only the owner sees ready/last from the master.
  always_comb begin
    s_ready = '0;
    s_last  = '0;
    grant   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (own && (g_q == IDX_W'(i))) begin
        s_ready[i] = m_ready;
        s_last[i]  = m_last;
        grant[i]   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// Self-checking bench for versat_databus_arbiter: a table of cycle vectors,
// hand-written corner-case sequences and a randomized run checked against a
// behavioural owner/pointer model.
module tb_versat_databus_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_REQ-1:0]          s_valid;
  logic [N_REQ-1:0]          s_ready;
  logic [N_REQ*ADDR_W-1:0]   s_addr;
  logic [N_REQ*DATA_W-1:0]   s_wdata;
  logic [N_REQ*STRB_W-1:0]   s_wstrb;
  logic [N_REQ*8-1:0]        s_len;
  logic [DATA_W-1:0]         s_rdata;
  logic [N_REQ-1:0]          s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic [STRB_W-1:0]         m_wstrb;
  logic [7:0]                m_len;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_last;
  logic [N_REQ-1:0]          grant;
  logic                      busy;

  int tests = 0;
  int fails = 0;

  // model state: current owner (-1 when idle) and last finished owner
  int mdl_owner;
  int mdl_ptr;

  always #5 clk = ~clk;

  versat_databus_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_len(s_len), .s_rdata(s_rdata), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_len(m_len), .m_rdata(m_rdata), .m_last(m_last),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic [3:0] sv;
    logic       mr;
    logic       ml;
    logic [3:0] gr;
    logic       mv;
    logic [3:0] sr;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dut_out();
    return {6'b0, m_valid, s_ready, s_rdata, s_last, m_addr, m_wdata, m_wstrb, m_len, grant, busy};
  endfunction

  function automatic logic [127:0] model_out();
    logic        own;
    int          o;
    logic        mv;
    logic [3:0]  sr, sl, gr, st;
    logic [31:0] a, w;
    logic [7:0]  ln;
    own = (mdl_owner >= 0);
    o   = own ? mdl_owner : 0;
    mv = 1'b0; sr = '0; sl = '0; gr = '0; st = '0; a = '0; w = '0; ln = '0;
    if (own) begin
      mv    = s_valid[o];
      sr[o] = m_ready;
      sl[o] = m_last;
      gr[o] = 1'b1;
      a     = s_addr[o*ADDR_W +: ADDR_W];
      w     = s_wdata[o*DATA_W +: DATA_W];
      st    = s_wstrb[o*STRB_W +: STRB_W];
      ln    = s_len[o*8 +: 8];
    end
    return {6'b0, mv, sr, m_rdata, sl, a, w, st, ln, gr, own};
  endfunction

  task automatic model_reset();
    mdl_owner = -1;
    mdl_ptr   = N_REQ - 1;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (mdl_owner < 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (mdl_ptr + k) % N_REQ;
        if (mdl_owner < 0 && s_valid[c]) mdl_owner = c;
      end
    end else if (s_valid[mdl_owner] && m_ready && m_last) begin
      mdl_ptr   = mdl_owner;
      mdl_owner = -1;
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input string name);
    settle();
    check(name, dut_out(), model_out());
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_ctrl", {m_valid, s_ready, s_last, grant, busy}, '0);
    check("reset_model", dut_out(), model_out());
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] st, input logic [7:0] ln);
    s_addr[i*ADDR_W +: ADDR_W]  = a;
    s_wdata[i*DATA_W +: DATA_W] = w;
    s_wstrb[i*STRB_W +: STRB_W] = st;
    s_len[i*8 +: 8]             = ln;
  endtask

  initial begin
    int acc;
    logic done;
    logic [3:0] fair_exp [4];
    logic       bp_mr [9];
    logic       bp_sv [9];

    rst = 1'b0; s_valid = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0; s_len = '0;
    m_ready = 1'b0; m_rdata = '0; m_last = 1'b0;
    model_reset();

    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 4'h1};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 4'h1};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'h2, 1'b1, 4'h2};
    tbl[5]  = '{4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 4'h2};
    tbl[6]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 4'h4};
    tbl[8]  = '{4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 4'h4};
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[10] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 4'h8};
    tbl[11] = '{4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 4'h8};
    tbl[12] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
    tbl[13] = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 4'h1};

    #1;
    do_reset();

    // all four requesting, bursts of two: round robin 0,1,2,3,0
    for (int i = 0; i < N_REQ; i++) set_req(i, 32'h100 * (i + 1), 32'hC0DE0000 + i, 4'hF, 8'd2);
    for (int i = 0; i < 14; i++) begin
      s_valid = tbl[i].sv; m_ready = tbl[i].mr; m_last = tbl[i].ml;
      settle();
      check($sformatf("table_row%0d", i), {grant, m_valid, s_ready}, {tbl[i].gr, tbl[i].mv, tbl[i].sr});
      check($sformatf("table_model%0d", i), dut_out(), model_out());
      advance();
    end

    // single requester 2, write burst of four
    do_reset();
    s_valid = 4'b0100; m_ready = 1'b1; m_last = 1'b0;
    set_req(2, 32'h1000, 32'hD0, 4'hF, 8'd4);
    settle();
    check("single_latency", {m_valid, grant}, 5'b0);
    advance();
    for (int b = 0; b < 4; b++) begin
      set_req(2, 32'h1000 + 4 * b, 32'hD0 + b, 4'hF, 8'd4);
      m_last = (b == 3);
      settle();
      check("single_beat", {m_valid, grant, m_addr, m_wdata},
            {1'b1, 4'b0100, 32'h1000 + 32'(4 * b), 32'hD0 + 32'(b)});
      check("single_model", dut_out(), model_out());
      advance();
    end
    s_valid = '0; m_last = 1'b0;
    settle();
    check("single_release", {grant, busy}, 5'b0);
    advance();

    // fairness between requesters 1 and 3, single-beat bursts
    do_reset();
    fair_exp[0] = 4'b0010; fair_exp[1] = 4'b1000; fair_exp[2] = 4'b0010; fair_exp[3] = 4'b1000;
    s_valid = 4'b1010; m_ready = 1'b1; m_last = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cycle("fair_idle");
      settle();
      check("fair_grant", grant, fair_exp[b]);
      check("fair_model", dut_out(), model_out());
      advance();
    end

    // backpressure, owner stall, and a stray m_last while not ready
    do_reset();
    bp_mr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bp_sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    s_valid = 4'b0001; m_ready = 1'b0; m_last = 1'b0;
    set_req(0, 32'h2000, 32'hBEEF, 4'hF, 8'd4);
    cycle("bp_idle");
    acc = 0; done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid = {3'b0, bp_sv[i]};
      m_ready = bp_mr[i];
      m_last  = (acc == 3) || (i == 1);
      settle();
      check("bp_grant", grant, done ? 4'b0000 : 4'b0001);
      check("bp_model", dut_out(), model_out());
      if (!done && bp_sv[i] && bp_mr[i]) begin
        if (acc == 3) done = 1'b1;
        acc++;
      end
      advance();
    end

    // read burst from requester 1
    do_reset();
    s_valid = 4'b0010; m_ready = 1'b1; m_last = 1'b0;
    set_req(1, 32'h3000, 32'h0, 4'h0, 8'd3);
    cycle("rd_idle");
    for (int b = 0; b < 3; b++) begin
      m_rdata = 32'hA5A50001 + 32'(b);
      m_last  = (b == 2);
      settle();
      check("rd_data", s_rdata, 32'hA5A50001 + 32'(b));
      check("rd_last", s_last, (b == 2) ? 4'b0010 : 4'b0000);
      check("rd_model", dut_out(), model_out());
      advance();
    end
    s_valid = '0; m_last = 1'b0;
    cycle("rd_done");

    // asynchronous reset mid-burst, with the pointer moved away from its reset value
    do_reset();
    s_valid = 4'b0001; m_ready = 1'b1; m_last = 1'b1;
    set_req(0, 32'h4000, 32'h11, 4'hF, 8'd1);
    set_req(3, 32'h4300, 32'h33, 4'hF, 8'd4);
    cycle("ar_idle0");
    cycle("ar_own0");
    s_valid = 4'b1000; m_last = 1'b0;
    cycle("ar_idle3");
    cycle("ar_beat1");
    settle();
    rst = 1'b1;
    #1;
    check("async_rst", {m_valid, s_ready, grant, busy}, 10'b0);
    model_reset();
    check("async_rst_model", dut_out(), model_out());
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_valid = 4'b1001;
    cycle("ar_post_idle");
    settle();
    check("post_rst_grant", grant, 4'b0001);
    check("post_rst_model", dut_out(), model_out());
    advance();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) s_valid = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      m_last  = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      for (int i = 0; i < N_REQ; i++) set_req(i, $urandom, $urandom, 4'($urandom), 8'($urandom));
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/versat_databus_arbiter.md
Name: versat_databus_arbiter

Overview:
- Shares a single external databus master port among N_REQ Versat IO units (VRead/VWrite-style databus interfaces).
- Requests are granted with round-robin priority.
- A grant is held for the whole burst, until the beat where m_valid & m_ready & m_last is accepted.
- Sits between the unit databus ports and the system-level memory interconnect.

Parameters:
- N_REQ, 4, number of requesting units (2..8)
- DATA_W, 32, databus data width
- ADDR_W, 32, databus address width (IO_ADDR_W)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- s_valid  input  N_REQ  per-requester request/beat valid
- s_ready  output  N_REQ  per-requester ready
- s_addr  input  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- s_wdata  input  N_REQ*DATA_W  packed write data
- s_wstrb  input  N_REQ*DATA_W/8  packed strobes; all-zero = read burst
- s_len  input  N_REQ*8  packed burst lengths
- s_rdata  output  DATA_W  broadcast read data
- s_last  output  N_REQ  per-requester last-beat indication
- m_valid  output  1  master valid
- m_ready  input  1  master ready
- m_addr  output  ADDR_W  selected address
- m_wdata  output  DATA_W  selected write data
- m_wstrb  output  DATA_W/8  selected strobe
- m_len  output  8  selected burst length
- m_rdata  input  DATA_W  master read data
- m_last  input  1  master last beat
- grant  output  N_REQ  one-hot current owner; 0 when idle
- busy  output  1  burst in progress

Behaviour:
- FSM has two states, IDLE and OWN. Internal state: grant index g and round-robin pointer ptr.
- Reset values: state=IDLE, grant=0, busy=0, m_valid=0, s_ready=0, s_last=0, ptr=N_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any s_valid is set, select the first set bit searching from (ptr+1) mod N_REQ upward with wrap-around.
  - Register it into g and go to OWN on the next edge.
  - No master traffic occurs in IDLE. The fixed arbitration latency is 1 cycle from s_valid to m_valid.
- OWN:
  - m_valid = s_valid[g].
  - m_addr, m_wdata, m_wstrb and m_len are muxed from requester g. They are combinational from the s_ side, with no added data latency.
  - s_ready[g] = m_ready; s_ready of every other requester is 0.
  - s_last[g] = m_last; other s_last bits are 0.
  - s_rdata = m_rdata at all times.
- Burst end:
  - When m_valid & m_ready & m_last in OWN, set ptr=g and go to IDLE. grant goes to 0 on the next cycle.
  - A re-request by any unit, including the just-finished one, waits one IDLE cycle.
  - The just-finished requester has the lowest priority in that arbitration.
- s_valid[g] deasserted mid-burst: the grant is held. The arbiter never preempts.
- m_last without m_valid & m_ready: ignored.
- Requests from non-owners in OWN: ignored and not latched. They are re-evaluated in IDLE from live s_valid.
- Master-side outputs are don't-care when m_valid=0 but must be driven (no X): use mux of g, or 0 in IDLE.
- grant is one-hot of g while in OWN; busy = (state==OWN).
- Reset asserted mid-burst:
  - Immediate return to the reset values, ptr included.
  - Any partial burst is abandoned; the requester must re-issue.
- Latency: zero-cycle combinational pass-through in OWN. Throughput is 1 beat/cycle when m_ready is held high.

Test Plan:
- Single requester: s_valid[2]=1, s_len=4, write, m_ready=1, m_last on beat 4.
  - m_valid rises 1 cycle after s_valid.
  - grant=4'b0100.
  - 4 beats pass with matching addr/wdata.
  - grant=0 the cycle after last.
- Simultaneous requests: all 4 requesters valid from reset, each burst len 2.
  - Grant order is 0,1,2,3,0.
  - Exactly one IDLE cycle between bursts.
  - Non-owner s_ready stays 0.
- Fairness: requesters 1 and 3 continuously valid.
  - Grants alternate 1,3,1,3.
  - Requester 1 re-requesting immediately never wins twice in a row while 3 is waiting.
- Backpressure and owner stall: m_ready toggles 1,0,0,1 during a burst, and s_valid[g] drops for 2 cycles mid-burst.
  - Grant is held.
  - Beats are transferred only when valid&ready.
  - No grant change until the accepted last beat.
- Read path: owner issues wstrb=0, len 3; master returns rdata 0xA5A5_0001..3 with m_last on the 3rd.
  - s_rdata matches.
  - s_last[g]=1 only on the 3rd beat; other s_last bits stay 0.
- Async reset mid-burst: assert rst during beat 2 of 4.
  - m_valid, s_ready, grant and busy drop to 0 immediately, without waiting for a clock edge.
  - After release with requesters 0 and 3 valid, requester 0 is granted first.
